// File: rtl/instr_encoder_loader.sv
// MIPS instruction encoder + instruction-memory loader: packs one descriptor
// per valid/ready beat into an R/I-type word and writes it to imem.
// Ports: clk, rst_n (async low), start, in_valid/in_ready, op_sel, rs, rt,
//   rd, shamt, imm, last -> imem_we/imem_addr/imem_wdata, busy, done,
//   err[1:0] (illegal op / capacity), count.
// Option: define ENC_ILLEGAL_TRAP_EN to drop illegal ops instead of
//   writing them as NOPs.
module instr_encoder_loader #(
    parameter int          ADDR_W    = 8,
    parameter int unsigned BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [4:0]        op_sel,
    input  logic [4:0]        rs,
    input  logic [4:0]        rt,
    input  logic [4:0]        rd,
    input  logic [4:0]        shamt,
    input  logic [15:0]       imm,
    input  logic              last,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              busy,
    output logic              done,
    output logic [1:0]        err,
    output logic [ADDR_W:0]   count
);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DONE} state_t;

    localparam logic [ADDR_W-1:0] BASE    = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W-1:0] PTR_MAX = '1;

`ifdef ENC_ILLEGAL_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    state_t              state_q, state_d;
    logic                imem_we_q;
    logic [ADDR_W-1:0]   imem_addr_q;
    logic [31:0]         imem_wdata_q;
    logic [ADDR_W-1:0]   ptr_q;
    logic [1:0]          err_q;
    logic [ADDR_W:0]     count_q;

    logic                accept;
    logic                illegal;
    logic                wr;
    logic                full;
    logic                fin;
    logic [31:0]         enc;

    assign accept  = in_valid && (state_q == S_LOAD);
    assign illegal = op_sel[4];
    // In trap mode an illegal beat is consumed without a write.
    assign wr      = accept && (!illegal || !TRAP);
    // Writing the top word without `last` means no room is left.
    assign full    = wr && !last && (ptr_q == PTR_MAX);
    assign fin     = accept && (last || full);

    always_comb begin
        enc = 32'h0;
        case (op_sel)
            5'd0:  enc = {6'b0, rs, rt, rd, 5'd0, 6'b100000};
            5'd1:  enc = {6'b0, rs, rt, rd, 5'd0, 6'b100010};
            5'd2:  enc = {6'b0, 5'd0, rt, rd, shamt, 6'b000000};
            5'd3:  enc = {6'b0, 5'd0, rt, rd, shamt, 6'b000010};
            5'd4:  enc = {6'b0, rs, rt, rd, 5'd0, 6'b100100};
            5'd5:  enc = {6'b0, rs, rt, rd, 5'd0, 6'b100101};
            5'd6:  enc = {6'b0, rs, rt, rd, 5'd0, 6'b101010};
            5'd7:  enc = {6'b0, rs, rt, rd, 5'd0, 6'b101011};
            5'd8:  enc = {6'b100011, rs, rt, imm};
            5'd9:  enc = {6'b101011, rs, rt, imm};
            5'd10: enc = {6'b000100, rs, rt, imm};
            5'd11: enc = {6'b100001, rs, rt, imm};
            5'd12: enc = {6'b100101, rs, rt, imm};
            5'd13: enc = {6'b001000, rs, rt, imm};
            5'd14: enc = {6'b001100, rs, rt, imm};
            5'd15: enc = {6'b001101, rs, rt, imm};
            default: enc = 32'h0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start) state_d = S_LOAD;
            S_LOAD:  if (fin)   state_d = S_DONE;
            S_DONE:  if (start) state_d = S_LOAD;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        in_ready = (state_q == S_LOAD);
        busy     = (state_q == S_LOAD);
        done     = (state_q == S_DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            imem_we_q    <= 1'b0;
            imem_addr_q  <= BASE;
            imem_wdata_q <= 32'h0;
            ptr_q        <= BASE;
            err_q        <= 2'b00;
            count_q      <= '0;
        end else begin
            imem_we_q <= wr;
            if (start && state_q != S_LOAD) begin
                ptr_q   <= BASE;
                err_q   <= 2'b00;
                count_q <= '0;
            end else begin
                // count tracks writes as they land, one edge after accept
                count_q <= count_q + {{ADDR_W{1'b0}}, imem_we_q};
                if (wr) begin
                    imem_addr_q  <= ptr_q;
                    imem_wdata_q <= enc;
                    ptr_q        <= ptr_q + 1'b1;
                end
                if (accept && illegal) err_q[0] <= 1'b1;
                if (full)              err_q[1] <= 1'b1;
            end
        end
    end

    assign imem_we    = imem_we_q;
    assign imem_addr  = imem_addr_q;
    assign imem_wdata = imem_wdata_q;
    assign err        = err_q;
    assign count      = count_q;

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Self-checking bench for instr_encoder_loader: directed timing steps plus
// random programs checked against an ISA-level reference model.
module tb_instr_encoder_loader;

    localparam int AW   = 2;
    localparam int MAXP = (1 << AW) - 1;

`ifdef ENC_ILLEGAL_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    typedef struct {
        logic [4:0]  op;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [4:0]  sh;
        logic [15:0] imm;
        bit          last;
    } desc_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [4:0]    op_sel = '0;
    logic [4:0]    rs = '0, rt = '0, rd = '0, shamt = '0;
    logic [15:0]   imm = '0;
    logic          last = 1'b0;
    logic          imem_we;
    logic [AW-1:0] imem_addr;
    logic [31:0]   imem_wdata;
    logic          busy, done;
    logic [1:0]    err;
    logic [AW:0]   count;

    int n_tests = 0;
    int n_fail  = 0;

    int          wa[$];
    logic [31:0] wd[$];
    int          ea[$];
    logic [31:0] ed[$];
    desc_t       prog[$];

    logic [5:0] FUNCT [8] = '{6'h20, 6'h22, 6'h00, 6'h02,
                              6'h24, 6'h25, 6'h2a, 6'h2b};
    logic [5:0] OPC   [8] = '{6'h23, 6'h2b, 6'h04, 6'h21,
                              6'h25, 6'h08, 6'h0c, 6'h0d};

    instr_encoder_loader #(.ADDR_W(AW), .BASE_ADDR(0)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .in_valid(in_valid), .in_ready(in_ready),
        .op_sel(op_sel), .rs(rs), .rt(rt), .rd(rd), .shamt(shamt),
        .imm(imm), .last(last),
        .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
        .busy(busy), .done(done), .err(err), .count(count)
    );

    always #5 clk = ~clk;

    // record every completed memory write
    always @(posedge clk) begin
        if (imem_we === 1'b1) begin
            wa.push_back(int'(imem_addr));
            wd.push_back(imem_wdata);
        end
    end

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] enc_ref(input desc_t d);
        bit shift;
        shift = (d.op == 5'd2) || (d.op == 5'd3);
        if (d.op < 5'd8)
            return {6'h0, shift ? 5'd0 : d.rs, d.rt, d.rd,
                    shift ? d.sh : 5'd0, FUNCT[d.op[2:0]]};
        else if (d.op < 5'd16)
            return {OPC[d.op[2:0]], d.rs, d.rt, d.imm};
        return 32'h0;
    endfunction

    function automatic desc_t mk(input int op, input int a, input int b,
                                 input int c, input int s, input int im,
                                 input bit l);
        desc_t d;
        d.op = 5'(op); d.rs = 5'(a); d.rt = 5'(b); d.rd = 5'(c);
        d.sh = 5'(s); d.imm = 16'(im); d.last = l;
        return d;
    endfunction

    task automatic drive(input desc_t d);
        op_sel = d.op; rs = d.rs; rt = d.rt; rd = d.rd;
        shamt = d.sh; imm = d.imm; last = d.last;
        in_valid = 1'b1;
    endtask

    task automatic pulse_start();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
    endtask

    // Load `prog` and compare the writes and final flags with the model.
    task automatic run_prog(input string tag);
        int ptr = 0, nacc = 0, got = 0, n;
        bit term = 0, ill;
        logic [1:0] eerr = 2'b00;
        ea.delete(); ed.delete();
        foreach (prog[i]) begin
            if (!term) begin
                nacc++;
                ill = prog[i].op > 5'd15;
                if (ill) eerr[0] = 1'b1;
                if (!ill || !TRAP) begin
                    ea.push_back(ptr);
                    ed.push_back(enc_ref(prog[i]));
                    if (!prog[i].last && ptr == MAXP) begin
                        eerr[1] = 1'b1;
                        term = 1;
                    end
                    ptr++;
                end
                if (prog[i].last) term = 1;
            end
        end
        pulse_start();
        wa.delete(); wd.delete();
        foreach (prog[i]) begin
            if (in_ready !== 1'b1) break;
            drive(prog[i]);
            got++;
            @(negedge clk);
        end
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        check({tag, " accepted"}, 64'(got), 64'(nacc));
        check({tag, " nwrites"}, 64'(wa.size()), 64'(ea.size()));
        n = (wa.size() < ea.size()) ? wa.size() : ea.size();
        for (int i = 0; i < n; i++) begin
            check($sformatf("%s addr%0d", tag, i), 64'(wa[i]), 64'(ea[i]));
            check($sformatf("%s data%0d", tag, i), 64'(wd[i]), 64'(ed[i]));
        end
        check({tag, " done"}, 64'(done), 64'(term));
        check({tag, " busy"}, 64'(busy), 64'(!term));
        check({tag, " ready"}, 64'(in_ready), 64'(!term));
        check({tag, " err"}, 64'(err), 64'(eerr));
        check({tag, " count"}, 64'(count), 64'(ea.size()));
    endtask

    initial begin
        int snap;
        #1;
        check("rst we", 64'(imem_we), 64'(0));
        check("rst ready", 64'(in_ready), 64'(0));
        check("rst addr", 64'(imem_addr), 64'(0));
        check("rst wdata", 64'(imem_wdata), 64'(0));
        check("rst busy", 64'(busy), 64'(0));
        check("rst done", 64'(done), 64'(0));
        check("rst err", 64'(err), 64'(0));
        check("rst count", 64'(count), 64'(0));
        @(negedge clk) rst_n = 1'b1;

        // valid while idle must be ignored
        drive(mk(0, 1, 2, 3, 0, 0, 0));
        repeat (3) @(negedge clk);
        in_valid = 1'b0;
        check("idle nowrite", 64'(wa.size()), 64'(0));
        check("idle count", 64'(count), 64'(0));

        // single ADD with last: exact write-cycle timing
        pulse_start();
        drive(mk(0, 1, 2, 3, 0, 0, 1));
        @(posedge clk) #1;
        in_valid = 1'b0;
        check("add we", 64'(imem_we), 64'(1));
        check("add addr", 64'(imem_addr), 64'(0));
        check("add wdata", 64'(imem_wdata), 64'h00221820);
        check("add done", 64'(done), 64'(1));
        check("add busy", 64'(busy), 64'(0));
        @(posedge clk) #1;
        check("add we1", 64'(imem_we), 64'(0));
        check("add count", 64'(count), 64'(1));
        check("add hold", 64'(done), 64'(1));

        prog = '{mk(8, 4, 5, 9, 9, 16'h0010, 0),
                 mk(10, 1, 2, 0, 0, 16'hFFFE, 1)};
        run_prog("lwbeq");
        check("lw word", 64'(wd.size() > 0 ? wd[0] : 0), 64'h8C850010);
        check("beq word", 64'(wd.size() > 1 ? wd[1] : 0), 64'h1022FFFE);

        prog = '{mk(2, 7, 2, 3, 4, 0, 1)};
        run_prog("sll");
        check("sll word", 64'(wd.size() > 0 ? wd[0] : 0), 64'h00021900);

        prog = '{mk(0, 1, 1, 1, 0, 0, 0), mk(1, 2, 2, 2, 0, 0, 0),
                 mk(4, 3, 3, 3, 0, 0, 0), mk(5, 4, 4, 4, 0, 0, 0),
                 mk(6, 5, 5, 5, 0, 0, 1)};
        run_prog("full");

        prog = '{mk(20, 1, 2, 3, 4, 5, 0),
                 mk(15, 6, 7, 0, 0, 16'h1234, 1)};
        run_prog("illegal");

        // async reset in the middle of a back-to-back burst
        pulse_start();
        drive(mk(13, 1, 2, 0, 0, 16'h0042, 0));
        @(posedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("mid we", 64'(imem_we), 64'(0));
        check("mid busy", 64'(busy), 64'(0));
        check("mid ready", 64'(in_ready), 64'(0));
        check("mid count", 64'(count), 64'(0));
        check("mid addr", 64'(imem_addr), 64'(0));
        check("mid wdata", 64'(imem_wdata), 64'(0));
        snap = wa.size();
        @(negedge clk) rst_n = 1'b1;
        repeat (4) @(negedge clk);
        check("post rst writes", 64'(wa.size()), 64'(snap));
        check("post rst ready", 64'(in_ready), 64'(0));
        in_valid = 1'b0;

        for (int t = 0; t < 40; t++) begin
            int len = $urandom_range(1, 6);
            prog.delete();
            for (int k = 0; k < len; k++)
                prog.push_back(mk($urandom_range(0, 19), $urandom,
                                  $urandom, $urandom, $urandom,
                                  $urandom, k == len - 1));
            run_prog($sformatf("rnd%0d", t));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/instr_encoder_loader.md
# instr_encoder_loader

- Sequential MIPS instruction encoder and instruction-memory loader: the producing end of the opcode/funct interface that the control decoder consumes.
- Accepts one instruction descriptor per handshake and packs it into a 32-bit R-type or I-type word.
- Writes the word into instruction memory at an auto-incrementing word address.
- Sits between the testbench/boot source and the instruction memory ahead of fetch.

## Interface

Parameters:
- ADDR_W, 8, instruction-memory word-address width.
- BASE_ADDR, 0, first word address written after `start`.

Ports:
- Clock and reset: one clock; reset is asynchronous and active-low.
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse that begins a program load.
- in_valid  in  1  descriptor valid.
- in_ready  out  1  block can accept a descriptor.
- op_sel  in  5  0 ADD, 1 SUB, 2 SLL, 3 SRL, 4 AND, 5 OR, 6 SLT, 7 SLTU, 8 LW, 9 SW, 10 BEQ, 11 LH, 12 LHU, 13 ADDI, 14 ANDI, 15 ORI; 16–31 illegal.
- rs, rt, rd, shamt  in  5 each  register and shift fields.
- imm  in  16  immediate or offset.
- last  in  1  marks the final descriptor of the program.
- imem_we  out  1  instruction-memory write strobe.
- imem_addr  out  ADDR_W  write word address.
- imem_wdata  out  32  encoded instruction.
- busy  out  1  high in LOAD.
- done  out  1  high in DONE.
- err  out  2  sticky flags: [0] illegal op_sel, [1] capacity exhausted before `last`.
- count  out  ADDR_W+1  words written since `start`.

## Operation

States: IDLE, LOAD, DONE.
- IDLE → LOAD on `start`.
- DONE → LOAD on `start`.
- On entering LOAD:
  - Address pointer is set to BASE_ADDR.
  - `count` and `err` are cleared.
- `start` is ignored while in LOAD.

Handshake:
- `in_ready` = (state == LOAD).
- A beat is accepted when `in_valid && in_ready`.
- `in_valid` without `in_ready` is ignored; nothing is queued.

R-type encoding (op_sel 0–7):
- Word = {6'b000000, rs, rt, rd, shamt, funct}.
- funct: ADD 100000, SUB 100010, SLL 000000, SRL 000010, AND 100100, OR 100101, SLT 101010, SLTU 101011.
- SLL/SRL force the rs field to 0.
- All other R-type ops force the shamt field to 0.

I-type encoding (op_sel 8–15):
- Word = {opcode, rs, rt, imm}.
- opcode: LW 100011, SW 101011, BEQ 000100, LH 100001, LHU 100101, ADDI 001000, ANDI 001100, ORI 001101.
- `rd` and `shamt` are ignored.

Pointer and termination:
- The pointer increments by 1 after each write.
- An accepted beat with `last` = 1: written normally; FSM goes to DONE on the same edge.
- Beat accepted at pointer = 2^ADDR_W−1 with `last` = 0: written; FSM goes to DONE; err[1] is set.
- No wrap-around write ever occurs.
- `last` together with an illegal op_sel also terminates the load (see Configuration).

## Timing

- Reset values: state IDLE, in_ready 0, imem_we 0, imem_addr BASE_ADDR, imem_wdata 0, busy 0, done 0, err 0, count 0.
- Latency is 1 cycle. For a beat accepted at edge N:
  - `imem_we`, `imem_addr` and `imem_wdata` are registered and valid during cycle N+1.
  - `imem_we` is high for exactly one cycle per write.
  - `count` increments at edge N+1.
- Throughput: 1 word per cycle with continuous `in_valid`.
- `busy` drops and `done` rises the cycle after the terminating beat is accepted, coincident with its `imem_we`.
- `done` holds until the next `start`.
- Reset asserted mid-load:
  - All outputs go to reset values immediately.
  - `imem_we` drops asynchronously.
  - No write completes after `rst_n` falls.

## Configuration

- ENC_ILLEGAL_TRAP_EN defined:
  - An illegal op_sel beat is accepted but not written.
  - `imem_we` stays 0, and the pointer and `count` do not advance.
  - err[0] is set.
- ENC_ILLEGAL_TRAP_EN undefined:
  - An illegal op_sel is written as NOP (32'h00000000).
  - Pointer and `count` advance normally.
  - err[0] is still set.

## Test plan

- Reset, `start`, one beat ADD rs=1 rt=2 rd=3 with `last` → cycle after accept: imem_we=1, addr=0, wdata=32'h00221820; then done=1, count=1.
- Burst of LW rs=4 rt=5 imm=16'h0010 followed by BEQ rs=1 rt=2 imm=16'hFFFE (`last`) with `in_valid` held → back-to-back writes: 32'h8C850010 at addr 0, 32'h1022FFFE at addr 1.
- SLL rt=2 rd=3 shamt=4 with rs=7 → wdata=32'h00021900 (rs forced 0).
- ADDR_W=2, 4 beats, no `last` → writes at addresses 0–3; then DONE with err=2'b10 and count=4; in_ready=0 afterwards.
- op_sel=20 then ORI (`last`):
  - With ENC_ILLEGAL_TRAP_EN: one write (ORI at addr 0), err[0]=1.
  - Without ENC_ILLEGAL_TRAP_EN: NOP at addr 0, ORI at addr 1.
- `rst_n` pulsed low mid-burst → imem_we=0 immediately; state IDLE; further `in_valid` ignored until `start`.
